fe_capture_ctrl: RTL and testbench

FE_CAPTURE_CTRL -- requirements
Module: fe_capture_ctrl

---
 rtl/fe_capture_ctrl_if.sv | 37 +++
 rtl/fe_capture_ctrl.sv | 126 ++++++++++++
 tb/tb_fe_capture_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fe_capture_ctrl_if.sv
// Front-end capture control bus: arm/trigger inputs, capture
// config, FIFO strobes and status flags of fe_capture_ctrl.
interface fe_capture_ctrl_if #(
    parameter int pDELAY_WIDTH = 20,
    parameter int pTRIGW_WIDTH = 17
);
    logic                    I_arm;
    logic                    I_pattern_match;
    logic                    I_capture_now;
    logic [pDELAY_WIDTH-1:0] I_trigger_delay;
    logic [pTRIGW_WIDTH-1:0] I_trigger_width;
    logic [15:0]             I_capture_len;
    logic                    I_data_wr;
    logic                    I_fifo_full;
    logic                    O_capture_enable;
    logic                    O_trig;
    logic                    O_armed;
    logic                    O_done;
    logic                    O_overflow;
    logic [2:0]              O_state;

    modport master (
        output I_arm, I_pattern_match, I_capture_now,
        output I_trigger_delay, I_trigger_width, I_capture_len,
        output I_data_wr, I_fifo_full,
        input  O_capture_enable, O_trig, O_armed,
        input  O_done, O_overflow, O_state
    );

    modport slave (
        input  I_arm, I_pattern_match, I_capture_now,
        input  I_trigger_delay, I_trigger_width, I_capture_len,
        input  I_data_wr, I_fifo_full,
        output O_capture_enable, O_trig, O_armed,
        output O_done, O_overflow, O_state
    );
endinterface

// File: rtl/fe_capture_ctrl.sv
// Capture controller: arm -> trigger -> delay -> capture -> done.
// Optional trigger-out pulse generator under FE_CTRL_TRIG_OUT_EN.
module fe_capture_ctrl #(
    parameter int pDELAY_WIDTH = 20,
    parameter int pTRIGW_WIDTH = 17
) (
    input  logic              fe_clk,
    input  logic              reset_n,
    fe_capture_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        DELAY   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    arm_q;
    logic                    trig_q;
    logic [pDELAY_WIDTH-1:0] dly_cnt;
    logic [15:0]             wr_cnt;
    logic [15:0]             wr_cnt_inc;
    logic                    len_hit;
    logic                    cap_en;
    logic                    armed;
    logic                    done;
    logic                    overflow;
    logic                    trig_out;

    assign wr_cnt_inc = (wr_cnt == 16'hFFFF) ? wr_cnt : wr_cnt + 16'd1;
    assign len_hit    = bus.I_data_wr && (bus.I_capture_len != 16'd0)
                        && (wr_cnt_inc == bus.I_capture_len);

    // Next-state decode; disarm overrides every other transition.
    always_comb begin
        state_nxt = state;
        if (!bus.I_arm) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (!arm_q) state_nxt = ARMED;
                ARMED:   if (trig_q)
                             state_nxt = (bus.I_trigger_delay == '0)
                                         ? CAPTURE : DELAY;
                DELAY:   if (dly_cnt <= 1) state_nxt = CAPTURE;
                CAPTURE: if (bus.I_fifo_full || len_hit)
                             state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, counters and registered status outputs.
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            arm_q    <= 1'b0;
            trig_q   <= 1'b0;
            dly_cnt  <= '0;
            wr_cnt   <= '0;
            cap_en   <= 1'b0;
            armed    <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state  <= state_nxt;
            arm_q  <= bus.I_arm;
            trig_q <= (state == ARMED) && bus.I_arm
                      && (bus.I_pattern_match || bus.I_capture_now);
            cap_en <= (state_nxt == CAPTURE);
            armed  <= (state_nxt == ARMED) || (state_nxt == DELAY)
                      || (state_nxt == CAPTURE);
            done   <= (state_nxt == DONE);
            if (state == ARMED && state_nxt == DELAY)
                dly_cnt <= bus.I_trigger_delay;
            else if (state == DELAY && dly_cnt != '0)
                dly_cnt <= dly_cnt - 1'b1;
            if (state != CAPTURE)
                wr_cnt <= '0;
            else if (bus.I_data_wr)
                wr_cnt <= wr_cnt_inc;
            if (state == IDLE && state_nxt == ARMED)
                overflow <= 1'b0;
            else if (state == CAPTURE && bus.I_arm && bus.I_fifo_full)
                overflow <= 1'b1;
        end
    end

`ifdef FE_CTRL_TRIG_OUT_EN
    logic [pTRIGW_WIDTH-1:0] trigw_cnt;

    // Trigger-out pulse: starts with capture enable, lasts width cycles.
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_out  <= 1'b0;
            trigw_cnt <= '0;
        end else if (!bus.I_arm) begin
            trig_out  <= 1'b0;
            trigw_cnt <= '0;
        end else if (state != CAPTURE && state_nxt == CAPTURE) begin
            trig_out  <= (bus.I_trigger_width != '0);
            trigw_cnt <= bus.I_trigger_width;
        end else if (trig_out) begin
            if (trigw_cnt <= 1) trig_out <= 1'b0;
            trigw_cnt <= trigw_cnt - 1'b1;
        end
    end
`else
    logic unused_trigw;
    assign unused_trigw = ^bus.I_trigger_width;
    assign trig_out     = 1'b0;
`endif

    assign bus.O_capture_enable = cap_en;
    assign bus.O_trig           = trig_out;
    assign bus.O_armed          = armed;
    assign bus.O_done           = done;
    assign bus.O_overflow       = overflow;
    assign bus.O_state          = state;

endmodule

// File: tb/tb_fe_capture_ctrl.sv
// Directed bench for fe_capture_ctrl: arm/trigger/delay/capture/done,
// overflow, disarm, re-arm and asynchronous reset.
module tb_fe_capture_ctrl;

    logic fe_clk  = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk   = 0;
    int   n_err   = 0;

    fe_capture_ctrl_if #(.pDELAY_WIDTH(20), .pTRIGW_WIDTH(17)) bus ();

    fe_capture_ctrl #(.pDELAY_WIDTH(20), .pTRIGW_WIDTH(17)) dut (
        .fe_clk  (fe_clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 fe_clk = ~fe_clk;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge fe_clk);
        #1;
    endtask

    task automatic cfg(input int dly, input int len, input int w);
        bus.I_trigger_delay = 20'(dly);
        bus.I_capture_len   = 16'(len);
        bus.I_trigger_width = 17'(w);
    endtask

    // Disarm then arm: leaves the FSM in ARMED.
    task automatic arm();
        bus.I_arm = 1'b0;
        tick();
        bus.I_arm = 1'b1;
        tick();
        check("arm_state", 32'(bus.O_state), 1);
    endtask

    task automatic pulse_match();
        bus.I_pattern_match = 1'b1;
        tick();
        bus.I_pattern_match = 1'b0;
    endtask

    initial begin
        bus.I_arm           = 1'b0;
        bus.I_pattern_match = 1'b0;
        bus.I_capture_now   = 1'b0;
        bus.I_data_wr       = 1'b0;
        bus.I_fifo_full     = 1'b0;
        cfg(0, 4, 3);
        #3;
        check("rst_state", 32'(bus.O_state), 0);
        check("rst_outs", {27'd0, bus.O_capture_enable, bus.O_trig,
              bus.O_armed, bus.O_done, bus.O_overflow}, 0);
        #9 reset_n = 1'b1;
        tick();
        check("idle_state", 32'(bus.O_state), 0);

        // delay 0, len 4
        arm();
        check("armed_flag", 32'(bus.O_armed), 1);
        pulse_match();
        check("t1_n_en", 32'(bus.O_capture_enable), 0);
        tick();
        check("t1_n1_en", 32'(bus.O_capture_enable), 1);
        check("t1_n1_state", 32'(bus.O_state), 3);
        bus.I_data_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_cap_state", 32'(bus.O_state), 3);
        end
        tick();
        bus.I_data_wr = 1'b0;
        check("t1_done_state", 32'(bus.O_state), 4);
        check("t1_done_en", 32'(bus.O_capture_enable), 0);
        check("t1_done_flag", 32'(bus.O_done), 1);
        check("t1_done_ovf", 32'(bus.O_overflow), 0);
        check("t1_done_armed", 32'(bus.O_armed), 0);

        // arm held high in DONE does not re-arm
        for (int i = 0; i < 3; i++) tick();
        check("hold_done", 32'(bus.O_state), 4);
        bus.I_arm = 1'b0;
        tick();
        check("done_to_idle", 32'(bus.O_state), 0);
        check("done_clr", 32'(bus.O_done), 0);

        // delay 5 via capture_now
        cfg(5, 4, 3);
        bus.I_arm = 1'b1;
        tick();
        check("rearm_state", 32'(bus.O_state), 1);
        bus.I_capture_now = 1'b1;
        tick();
        bus.I_capture_now = 1'b0;
        check("t2_n_state", 32'(bus.O_state), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_delay_state", 32'(bus.O_state), 2);
            check("t2_delay_en", 32'(bus.O_capture_enable), 0);
        end
        tick();
        check("t2_n6_en", 32'(bus.O_capture_enable), 1);
`ifdef FE_CTRL_TRIG_OUT_EN
        check("t2_trig0", 32'(bus.O_trig), 1);
        tick();
        check("t2_trig1", 32'(bus.O_trig), 1);
        tick();
        check("t2_trig2", 32'(bus.O_trig), 1);
        tick();
        check("t2_trig3", 32'(bus.O_trig), 0);
`else
        check("t2_trig_tied", 32'(bus.O_trig), 0);
        tick();
        check("t2_trig_tied1", 32'(bus.O_trig), 0);
`endif
        // disarm mid-CAPTURE
        bus.I_arm = 1'b0;
        tick();
        check("t2_dis_state", 32'(bus.O_state), 0);
        check("t2_dis_en", 32'(bus.O_capture_enable), 0);
        check("t2_dis_trig", 32'(bus.O_trig), 0);
        check("t2_dis_armed", 32'(bus.O_armed), 0);

        // disarm mid-DELAY
        arm();
        pulse_match();
        tick();
        check("t3_delay", 32'(bus.O_state), 2);
        tick();
        bus.I_arm = 1'b0;
        tick();
        check("t3_dis_state", 32'(bus.O_state), 0);
        check("t3_dis_en", 32'(bus.O_capture_enable), 0);

        // unlimited length, overflow on fifo_full
        cfg(0, 0, 3);
        arm();
        pulse_match();
        tick();
        check("t4_cap", 32'(bus.O_state), 3);
        bus.I_data_wr = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        bus.I_data_wr = 1'b0;
        check("t4_still_cap", 32'(bus.O_state), 3);
        bus.I_fifo_full = 1'b1;
        tick();
        bus.I_fifo_full = 1'b0;
        check("t4_done", 32'(bus.O_state), 4);
        check("t4_ovf", 32'(bus.O_overflow), 1);
        check("t4_en", 32'(bus.O_capture_enable), 0);
        pulse_match();
        tick();
        check("t4_match_done", 32'(bus.O_state), 4);
        check("t4_match_en", 32'(bus.O_capture_enable), 0);
        arm();
        check("t4_rearm_ovf", 32'(bus.O_overflow), 0);

        // length reached together with fifo_full
        cfg(0, 2, 0);
        pulse_match();
        tick();
        bus.I_data_wr = 1'b1;
        tick();
        check("t5_one_wr", 32'(bus.O_state), 3);
        bus.I_fifo_full = 1'b1;
        tick();
        bus.I_data_wr   = 1'b0;
        bus.I_fifo_full = 1'b0;
        check("t5_done", 32'(bus.O_state), 4);
        check("t5_ovf", 32'(bus.O_overflow), 1);

        // asynchronous reset mid-CAPTURE
        cfg(0, 0, 3);
        arm();
        pulse_match();
        tick();
        check("t6_cap", 32'(bus.O_state), 3);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_state", 32'(bus.O_state), 0);
        check("t6_rst_outs", {27'd0, bus.O_capture_enable, bus.O_trig,
              bus.O_armed, bus.O_done, bus.O_overflow}, 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("t6_post_rst", 32'(bus.O_state), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
